// File: rtl/cim_pkg.sv
// Shared types and width helpers for the crossbar-tile responder.
package cim_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    ADC     = 2'd2
  } state_e;

  function automatic int addr_w(input int xs);
    return (xs > 1) ? $clog2(xs) : 1;
  endfunction

  function automatic int acc_w(input int dw, input int xs);
    return dw + $clog2(xs);
  endfunction

endpackage

// File: rtl/cim_tile_responder_if.sv
// fc_layer <-> CIM tile bus: input-row writes, weight programming, start/busy/done, column reads.
interface cim_tile_responder_if
  import cim_pkg::*;
#(
  parameter int datatype_size = 4,
  parameter int xbar_size     = 512
);
  localparam int aw = addr_w(xbar_size);

  logic                     i_we;
  logic [aw-1:0]            i_wr_addr;
  logic [datatype_size-1:0] i_wr_data;
  logic                     i_w_we;
  logic [aw-1:0]            i_w_row;
  logic [aw-1:0]            i_w_col;
  logic                     i_w_bit;
  logic                     i_start;
  logic                     o_busy;
  logic                     o_done;
  logic [aw-1:0]            i_rd_addr;
  logic [datatype_size-1:0] o_rd_data;

  modport master (
    output i_we, i_wr_addr, i_wr_data, i_w_we, i_w_row, i_w_col, i_w_bit,
           i_start, i_rd_addr,
    input  o_busy, o_done, o_rd_data
  );

  modport slave (
    input  i_we, i_wr_addr, i_wr_data, i_w_we, i_w_row, i_w_col, i_w_bit,
           i_start, i_rd_addr,
    output o_busy, o_done, o_rd_data
  );
endinterface

// File: rtl/cim_adc.sv
// Per-column quantiser: right shift, then saturate (CIM_ADC_SAT_EN) or wrap to datatype_size bits.
module cim_adc #(
  parameter int acc_width     = 13,
  parameter int datatype_size = 4,
  parameter int adc_shift     = 9
) (
  input  logic [acc_width-1:0]     acc_i,
  output logic [datatype_size-1:0] q_o
);
  logic [acc_width-1:0] shifted;

  assign shifted = acc_i >> adc_shift;

`ifdef CIM_ADC_SAT_EN
  assign q_o = (|shifted[acc_width-1:datatype_size]) ? {datatype_size{1'b1}}
                                                      : shifted[datatype_size-1:0];
`else
  logic unused_hi;
  assign unused_hi = ^shifted[acc_width-1:datatype_size];
  assign q_o       = shifted[datatype_size-1:0];
`endif
endmodule

// File: rtl/cim_tile_responder.sv
// Behavioural CIM tile: row-sequential binary-weight MVM over all columns, ADC, registered read.
// Optional saturation in the ADC stage is selected by CIM_ADC_SAT_EN.
//   state   | meaning
//   IDLE    | accept input/weight writes and start; results stable
//   COMPUTE | accumulate one crossbar row per cycle into every column
//   ADC     | quantise accumulators into the output registers, pulse done
module cim_tile_responder
  import cim_pkg::*;
#(
  parameter int datatype_size = 4,
  parameter int xbar_size     = 512,
  parameter int adc_shift     = 9
) (
  input logic               clk,
  input logic               rst,
  cim_tile_responder_if.slave bus
);
  localparam int acc_width = acc_w(datatype_size, xbar_size);
  localparam int aw        = addr_w(xbar_size);

  state_e                   state_q, state_d;
  logic [aw-1:0]            row_q, row_d;
  logic                     done_q;
  logic [datatype_size-1:0] rd_q;
  logic [datatype_size-1:0] in_q  [xbar_size];
  logic [xbar_size-1:0]     w_q   [xbar_size];
  logic [acc_width-1:0]     acc_q [xbar_size];
  logic [datatype_size-1:0] out_q [xbar_size];
  logic [datatype_size-1:0] adc_q [xbar_size];
  logic                     idle, start_ok;

  assign idle     = (state_q == IDLE);
  assign start_ok = idle && bus.i_start;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = COMPUTE;
          row_d   = '0;
        end
      end
      COMPUTE: begin
        row_d = row_q + 1'b1;
        if (row_q == aw'(xbar_size - 1)) begin
          state_d = ADC;
          row_d   = '0;
        end
      end
      ADC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      done_q  <= 1'b0;
      rd_q    <= '0;
      for (int c = 0; c < xbar_size; c++) begin
        in_q[c]  <= '0;
        acc_q[c] <= '0;
        out_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      done_q  <= (state_q == ADC);
      rd_q    <= out_q[bus.i_rd_addr];
      // Write in the start cycle lands before row 0 is read on the next edge.
      if (idle && bus.i_we) in_q[bus.i_wr_addr] <= bus.i_wr_data;
      for (int c = 0; c < xbar_size; c++) begin
        if (start_ok) begin
          acc_q[c] <= '0;
        end else if (state_q == COMPUTE && w_q[row_q][c]) begin
          acc_q[c] <= acc_q[c] + acc_width'(in_q[row_q]);
        end
        if (state_q == ADC) out_q[c] <= adc_q[c];
      end
    end
  end

  // Weight cells model non-volatile devices: no reset, programmed only in IDLE.
  always_ff @(posedge clk) begin
    if (idle && bus.i_w_we) w_q[bus.i_w_row][bus.i_w_col] <= bus.i_w_bit;
  end

  for (genvar g = 0; g < xbar_size; g++) begin : g_adc
    cim_adc #(
      .acc_width    (acc_width),
      .datatype_size(datatype_size),
      .adc_shift    (adc_shift)
    ) u_adc (
      .acc_i(acc_q[g]),
      .q_o  (adc_q[g])
    );
  end

  assign bus.o_busy    = !idle;
  assign bus.o_done    = done_q;
  assign bus.o_rd_data = rd_q;
endmodule
